// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencer for stalls, flushes, divide freeze and syscall halt; HAZARD_PERF_EN enables the stall counter
module hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_BITS = 6,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic [REG_BITS-1:0] ex_rw,
  input  logic                ex_regwrite,
  input  logic                ex_memtoreg,
  input  logic                ex_branch_taken,
  input  logic                ex_div,
  input  logic                halt_req,
  input  logic                resume,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                idex_en,
  output logic                exmem_en,
  output logic                memwb_en,
  output logic                ifid_zero,
  output logic                idex_zero,
  output logic                exmem_zero,
  output logic                memwb_zero,
  output logic                halted,
  output logic                div_busy,
  output logic [31:0]         perf_stall_cnt
);
  typedef enum logic [1:0] {RUN, DIV_WAIT, HALT} state_t;
  state_t r_state, w_nxt, w_mode;
  logic [CNT_BITS-1:0] r_cnt, w_cnt_nxt;
  logic r_ret, w_ret_nxt, w_halt, w_hz, w_halted, w_busy;
  logic [4:0] w_en;
  logic [3:0] w_zr;
  assign w_hz = ex_memtoreg && ex_regwrite && ex_rw != '0 &&
                ((id_uses_rs && id_rs == ex_rw) || (id_uses_rt && id_rt == ex_rw));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt <= '0;
      r_ret <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= w_cnt_nxt;
      r_ret <= w_ret_nxt;
    end
  // A resumed HALT behaves exactly like the state it interrupted, minus the halt request
  always_comb begin
    w_en = '1;
    w_zr = '0;
    w_halted = 1'b0;
    w_nxt = r_state;
    w_cnt_nxt = r_cnt;
    w_ret_nxt = r_ret;
    w_mode = r_state;
    w_halt = halt_req;
    if (r_state == HALT) begin
      w_mode = resume ? (r_ret ? DIV_WAIT : RUN) : HALT;
      w_halt = 1'b0;
    end
    w_busy = w_mode == DIV_WAIT;
    if (w_mode == HALT) begin
      w_en = '0;
      w_halted = 1'b1;
    end else if (w_halt) begin
      w_en = '0;
      w_nxt = HALT;
      w_ret_nxt = w_mode == DIV_WAIT;
    end else if ((w_mode == RUN && ex_div) || (w_mode == DIV_WAIT && r_cnt != '0)) begin
      w_en = 5'b00011;
      w_zr = 4'b0010;
      w_nxt = DIV_WAIT;
      w_cnt_nxt = w_mode == RUN ? CNT_BITS'(DIV_CYCLES - 1) : r_cnt - CNT_BITS'(1);
    end else begin
      w_nxt = RUN;
      if (ex_branch_taken) w_zr = 4'b1100;
      else if (w_hz) begin
        w_en = 5'b00111;
        w_zr = 4'b0100;
      end
    end
    if (!rst_n) begin
      w_en = '0;
      w_zr = '1;
      w_halted = 1'b0;
      w_busy = 1'b0;
    end
  end
  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = w_en;
  assign {ifid_zero, idex_zero, exmem_zero, memwb_zero} = w_zr;
  assign halted = w_halted;
  assign div_busy = w_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_perf <= '0;
    else if (!w_en[4]) r_perf <= r_perf + 32'd1;
  assign perf_stall_cnt = r_perf;
`else
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized scoreboard bench for hazard_ctrl against a rule-level pipeline model
module tb_hazard_ctrl;
  localparam int DC = 4;
  localparam logic [10:0] DEF = 11'b11111_0000_00, RST = 11'b00000_1111_00,
    HLD = 11'b00000_0000_10, FRZ = 11'b00011_0010_00, BR = 11'b11111_1100_00,
    LU = 11'b00111_0100_00, ALL0 = 11'b0;
  typedef struct packed {logic [10:0] v; logic [31:0] p;} exp_t;
  logic clk = 0, rst_n = 0;
  logic [4:0] id_rs = 0, id_rt = 0, ex_rw = 0;
  logic id_uses_rs = 0, id_uses_rt = 0, ex_regwrite = 0, ex_memtoreg = 0;
  logic ex_branch_taken = 0, ex_div = 0, halt_req = 0, resume = 0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_zero, idex_zero, exmem_zero, memwb_zero, halted, div_busy;
  logic [31:0] perf_stall_cnt;
  exp_t q[$];
  int checks = 0, errors = 0;
  int m_mode = 0, m_left = 0, m_ret = 0;
  logic [31:0] m_perf = 0;
  hazard_ctrl #(.DIV_CYCLES(DC), .CNT_BITS(3), .REG_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rw(ex_rw),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_branch_taken(ex_branch_taken), .ex_div(ex_div), .halt_req(halt_req),
    .resume(resume), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_zero(ifid_zero),
    .idex_zero(idex_zero), .exmem_zero(exmem_zero), .memwb_zero(memwb_zero),
    .halted(halted), .div_busy(div_busy), .perf_stall_cnt(perf_stall_cnt));
  always #5 clk = ~clk;
  // mode: 0 running, 1 divide freeze, 2 halted; m_left = frozen cycles still owed by the divide
  task automatic drive(input logic rn, input logic [4:0] rs, rt, rw,
                       input logic urs, urt, rwr, mtr, br, dv, hr, rsm);
    exp_t e;
    int mode;
    logic h, hz;
    @(posedge clk);
    #1;
    {rst_n, id_rs, id_rt, ex_rw} = {rn, rs, rt, rw};
    {id_uses_rs, id_uses_rt, ex_regwrite, ex_memtoreg} = {urs, urt, rwr, mtr};
    {ex_branch_taken, ex_div, halt_req, resume} = {br, dv, hr, rsm};
    hz = mtr && rwr && rw != 0 && ((urs && rs == rw) || (urt && rt == rw));
    mode = m_mode;
    h = hr;
    if (!rn) begin
      e.v = RST;
      m_mode = 0; m_left = 0; m_ret = 0; m_perf = 0;
    end else begin
      if (m_mode == 2 && rsm) begin mode = m_ret; h = 0; end
      if (mode == 2) e.v = HLD;
      else if (h) begin
        e.v = ALL0 | 11'(mode == 1);
        m_ret = mode; m_mode = 2;
      end else if (mode == 0 && dv) begin
        e.v = FRZ;
        m_left = DC - 1; m_mode = 1;
      end else if (mode == 1 && m_left > 0) begin
        e.v = FRZ | 11'd1;
        m_left--; m_mode = 1;
      end else begin
        e.v = (br ? BR : hz ? LU : DEF) | 11'(mode == 1);
        m_mode = 0;
      end
    end
`ifdef HAZARD_PERF_EN
    e.p = m_perf;
    if (rn && !e.v[10]) m_perf = m_perf + 1;
`else
    e.p = 0;
`endif
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  always @(negedge clk) if (q.size() != 0) begin
    exp_t e;
    logic [10:0] a;
    e = q.pop_front();
    a = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_zero, idex_zero,
         exmem_zero, memwb_zero, halted, div_busy};
    checks++;
    if (a !== e.v) begin
      errors++;
      $display("FAIL ctrl t=%0t actual=%b required=%b", $time, a, e.v);
    end
    checks++;
    if (perf_stall_cnt !== e.p) begin
      errors++;
      $display("FAIL perf t=%0t actual=%0d required=%0d", $time, perf_stall_cnt, e.p);
    end
  end
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    drive(1, 8, 0, 8, 1, 0, 1, 1, 0, 0, 0, 0);
    idle(1);
    drive(1, 8, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    drive(1, 3, 8, 8, 0, 1, 1, 1, 1, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(6);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(99) != 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
            5'($urandom_range(3)), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom_range(4) == 0, $urandom_range(9) == 0,
            $urandom_range(11) == 0, $urandom_range(3) == 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
